// File: rtl/mdu_seq_pkg.sv
// Shared types for the iterative multiply/divide sequencer.
// Op codes match the decoder's MDUOp field.
package mdu_seq_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic is_div(mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed(mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// EX-stage <-> MDU bundle: operation request, HI/LO moves,
// register read-back and hazard status.
interface mdu_seq_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hilo_use;
  logic             mthi;
  logic             mtlo;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;

  modport master (
    output start, md_op, rs_data, rt_data,
    output hilo_use, mthi, mtlo, flush,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  start, md_op, rs_data, rt_data,
    input  hilo_use, mthi, mtlo, flush,
    output hi, lo, busy, stall
  );

endinterface

// File: rtl/mdu_seq_step.sv
// One multiply (shift-add) or restoring-divide iteration
// on the {hi,lo} working pair.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] dif;
  logic             ge;

  assign sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
  assign sh  = {hi_i, lo_i[WIDTH-1]};
  assign ge  = sh >= {1'b0, b_i};
  // remainder < divisor < 2^WIDTH, so the low bits suffice
  assign dif = sh[WIDTH-1:0] - b_i;

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    unique case (1'b1)
      is_div_i: begin
        hi_o = ge ? dif : sh[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], ge};
      end
      default: begin
        hi_o = sum[WIDTH:1];
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
      end
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO;
// stalls HI/LO consumers while an operation is in flight.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic   clk,
  input  logic   rst_n,
  mdu_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             nq_q, nq_d;
  logic             nr_q, nr_d;

  logic [WIDTH-1:0]   st_hi, st_lo;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [2*WIDTH-1:0] prod, prod_fix;
  mdu_op_e            op_in;
  logic               sgn, rs_neg, rt_neg;
  logic               busy, stall, accept, mt_ok;

  assign busy  = state_q != MDU_IDLE;
  assign stall = busy & (bus.start | bus.hilo_use);

  assign bus.busy  = busy;
  assign bus.stall = stall;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  assign op_in  = mdu_op_e'(bus.md_op);
  assign sgn    = is_signed(op_in);
  assign rs_neg = sgn & bus.rs_data[WIDTH-1];
  assign rt_neg = sgn & bus.rt_data[WIDTH-1];
  assign rs_abs = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_abs = rt_neg ? -bus.rt_data : bus.rt_data;

  assign accept = bus.start & ~stall & ~bus.flush;
  assign mt_ok  = ~bus.start & ~stall & ~bus.flush;

  assign prod     = {wh_q, wl_q};
  assign prod_fix = nq_q ? -prod : prod;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div(op_q)),
    .hi_i     (wh_q),
    .lo_i     (wl_q),
    .b_i      (b_q),
    .hi_o     (st_hi),
    .lo_o     (st_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          state_d = MDU_RUN;
          cnt_d   = '0;
          op_d    = op_in;
          wh_d    = '0;
          wl_d    = rs_abs;
          b_d     = rt_abs;
          // a zero divisor keeps the all-ones quotient unsigned
          nq_d    = (rs_neg ^ rt_neg) & (bus.rt_data != '0);
          nr_d    = rs_neg;
        end else if (mt_ok) begin
          if (bus.mthi) hi_d = bus.rs_data;
          if (bus.mtlo) lo_d = bus.rs_data;
        end
      end
      MDU_RUN: begin
        wh_d  = st_hi;
        wl_d  = st_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        if (is_div(op_q)) begin
          lo_d = nq_q ? -wl_q : wl_q;
          hi_d = nr_q ? -wh_q : wh_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
    if (busy && bus.flush) begin
      state_d = MDU_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULT;
      wh_q    <= '0;
      wl_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
    end
  end

endmodule
